// File: rtl/tensor_stream_reader_if.sv
// Output pixel stream of tensor_stream_reader: one tagged word per beat.
// A beat transfers on a cycle where out_valid && out_ready; while out_valid is
// high and out_ready is low, the producer holds out_data/row/col/last unchanged.
interface tensor_stream_reader_if #(
    parameter int D_WIDTH = 32,
    parameter int MAX_W   = 32,
    parameter int MAX_H   = 32
);
    localparam int ROW_W = $clog2(MAX_H);
    localparam int COL_W = $clog2(MAX_W);

    logic               out_valid;
    logic               out_ready;
    logic [D_WIDTH-1:0] out_data;
    logic [ROW_W-1:0]   out_row;
    logic [COL_W-1:0]   out_col;
    logic               out_last;

    modport master (
        output out_valid, out_data, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/tensor_stream_reader.sv
// Walks a WxH sub-window of tensor_ram row-major and streams each word with
// row/col/last tags through a small credit-controlled output FIFO.
module tensor_stream_reader #(
    parameter int D_WIDTH    = 32,
    parameter int MAX_W      = 32,
    parameter int MAX_H      = 32,
    parameter int DEPTH      = 1024,
    parameter int FIFO_DEPTH = 2,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int CW_W      = $clog2(MAX_W + 1),
    localparam int CH_W      = $clog2(MAX_H + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     cfg_base,
    input  logic [ADDR_W-1:0]     cfg_pitch,
    input  logic [CW_W-1:0]       cfg_w,
    input  logic [CH_W-1:0]       cfg_h,
    output logic                  ram_re,
    output logic [ADDR_W-1:0]     ram_addr,
    input  logic [D_WIDTH-1:0]    ram_dout,
    tensor_stream_reader_if.master out_if,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_dbg
);
    localparam int ROW_W = $clog2(MAX_H);
    localparam int COL_W = $clog2(MAX_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [CW_W-1:0]   w_q;
    logic [CH_W-1:0]   h_q;
    logic [ADDR_W-1:0] pitch_q;
    logic [ADDR_W-1:0] row_base;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;

    logic              inflight;
    logic [ROW_W-1:0]  inf_row;
    logic [COL_W-1:0]  inf_col;
    logic              inf_last;

    logic [D_WIDTH-1:0] f_data [FIFO_DEPTH];
    logic [ROW_W-1:0]   f_row  [FIFO_DEPTH];
    logic [COL_W-1:0]   f_col  [FIFO_DEPTH];
    logic               f_last [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   fifo_count;

    logic             col_end, row_end, issue_last;
    logic [OCC_W-1:0] occupancy;
    logic             fifo_empty, pop_any, fifo_push, fifo_pop, drained;

    // occupancy counts the FIFO plus the read whose data is still on ram_dout;
    // bounding it by FIFO_DEPTH is what makes a FIFO overflow impossible.
    always_comb begin
        col_end    = (CW_W'(col) == w_q - CW_W'(1));
        row_end    = (CH_W'(row) == h_q - CH_W'(1));
        issue_last = col_end && row_end;
        occupancy  = OCC_W'(fifo_count) + OCC_W'(inflight);
        ram_re     = (state == ISSUE) && (occupancy < OCC_W'(FIFO_DEPTH));
        ram_addr   = row_base + ADDR_W'(col);
        fifo_empty = (fifo_count == '0);
        pop_any    = out_if.out_valid && out_if.out_ready;
        fifo_pop   = !fifo_empty && out_if.out_ready;
        // With an empty FIFO the arriving word is offered directly and only
        // stored if the consumer does not take it this cycle.
        fifo_push  = inflight && !(fifo_empty && out_if.out_ready);
        drained    = ((occupancy - OCC_W'(pop_any)) == '0);
    end

    assign out_if.out_valid = !fifo_empty || inflight;
    assign out_if.out_data  = !fifo_empty ? f_data[rd_ptr] : (inflight ? ram_dout : '0);
    assign out_if.out_row   = !fifo_empty ? f_row[rd_ptr]  : (inflight ? inf_row  : '0);
    assign out_if.out_col   = !fifo_empty ? f_col[rd_ptr]  : (inflight ? inf_col  : '0);
    assign out_if.out_last  = !fifo_empty ? f_last[rd_ptr] : (inflight && inf_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Zero-size tiles pass through DRAIN, where nothing is outstanding, so
    // done lands two cycles after start just as a first beat would.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = (cfg_w == '0 || cfg_h == '0) ? DRAIN : ISSUE;
            ISSUE: if (ram_re && issue_last) state_nx = DRAIN;
            DRAIN: if (drained) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ISSUE) || (state == DRAIN);
        done      = (state == DONE);
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q      <= '0;
            h_q      <= '0;
            pitch_q  <= '0;
            row_base <= '0;
            col      <= '0;
            row      <= '0;
            inflight <= 1'b0;
            inf_row  <= '0;
            inf_col  <= '0;
            inf_last <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                w_q      <= cfg_w;
                h_q      <= cfg_h;
                pitch_q  <= cfg_pitch;
                row_base <= cfg_base;
                col      <= '0;
                row      <= '0;
            end else if (ram_re) begin
                if (col_end) begin
                    col      <= '0;
                    row      <= row + 1'b1;
                    row_base <= row_base + pitch_q;
                end else begin
                    col <= col + 1'b1;
                end
            end
            inflight <= ram_re;
            if (ram_re) begin
                inf_row  <= row;
                inf_col  <= col;
                inf_last <= issue_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (fifo_push && !fifo_pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!fifo_push && fifo_pop) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            f_data[wr_ptr] <= ram_dout;
            f_row[wr_ptr]  <= inf_row;
            f_col[wr_ptr]  <= inf_col;
            f_last[wr_ptr] <= inf_last;
        end
    end
endmodule

// File: tb/tb_tensor_stream_reader.sv
// Directed bench for tensor_stream_reader: tile model feeds an expected queue
// that a per-cycle monitor checks, plus literal latency/data expectations.
module tb_tensor_stream_reader;
    localparam int D_WIDTH    = 32;
    localparam int MAX_W      = 32;
    localparam int MAX_H      = 32;
    localparam int DEPTH      = 1024;
    localparam int FIFO_DEPTH = 2;
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int CW_W       = $clog2(MAX_W + 1);
    localparam int CH_W       = $clog2(MAX_H + 1);
    localparam int ROW_W      = $clog2(MAX_H);
    localparam int COL_W      = $clog2(MAX_W);
    localparam int EW         = D_WIDTH + ROW_W + COL_W + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] cfg_base, cfg_pitch;
    logic [CW_W-1:0]   cfg_w;
    logic [CH_W-1:0]   cfg_h;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [D_WIDTH-1:0] ram_dout = '0;
    logic              busy, done;
    logic [1:0]        state_dbg;

    tensor_stream_reader_if #(.D_WIDTH(D_WIDTH), .MAX_W(MAX_W), .MAX_H(MAX_H)) sif ();

    tensor_stream_reader #(
        .D_WIDTH(D_WIDTH), .MAX_W(MAX_W), .MAX_H(MAX_H),
        .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_base(cfg_base), .cfg_pitch(cfg_pitch), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .ram_re(ram_re), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .out_if(sif), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [D_WIDTH-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = D_WIDTH'(i);
    always @(posedge clk) if (ram_re) ram_dout <= mem[ram_addr];

    // scoreboard state
    logic [EW-1:0]      exp_q[$];
    logic [ADDR_W-1:0]  exp_addr_q[$];
    logic [D_WIDTH-1:0] obs_data[$];
    logic [ADDR_W-1:0]  obs_addr[$];
    int checks = 0, failures = 0;
    int beats, first_valid_cyc, last_hs_cyc, done_cyc, start_cyc;
    int done_count = 0, issued = 0, accepted = 0;
    bit bp_mode = 0;
    bit prev_stall = 0;
    logic [EW-1:0] prev_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Tile model: row-major walk, address = base + r*pitch + c modulo RAM depth.
    task automatic model_tile(input int base, input int pitch, input int w, input int h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int addr;
                addr = (base + r * pitch + c) % DEPTH;
                exp_addr_q.push_back(ADDR_W'(addr));
                exp_q.push_back({mem[addr], ROW_W'(r), COL_W'(c), (r == h - 1) && (c == w - 1)});
            end
        end
    endtask

    // out_ready driver: constant 1, or the repeating 1,0,0,1 pattern
    initial begin
        logic [3:0] bp_pat;
        int k;
        bp_pat = 4'b1001;
        k = 0;
        sif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                sif.out_ready = bp_pat[k % 4];
                k++;
            end else begin
                sif.out_ready = 1'b1;
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            int outstanding;
            logic [EW-1:0] cur;
            outstanding = issued - accepted;
            cur = {sif.out_data, sif.out_row, sif.out_col, sif.out_last};
            if (prev_stall) check("stall_hold", 64'({sif.out_valid, cur}), 64'({1'b1, prev_beat}));
            if (sif.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (sif.out_valid && sif.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 64'(1), 64'(0));
                end else begin
                    check("beat", 64'(cur), 64'(exp_q.pop_front()));
                end
                obs_data.push_back(sif.out_data);
                beats++;
                last_hs_cyc = cyc;
                accepted++;
            end
            prev_stall = sif.out_valid && !sif.out_ready;
            prev_beat  = cur;
            if (ram_re) begin
                check("credit", 64'(outstanding < FIFO_DEPTH), 64'(1));
                if (exp_addr_q.size() == 0) check("read_unexpected", 64'(1), 64'(0));
                else check("ram_addr", 64'(ram_addr), 64'(exp_addr_q.pop_front()));
                obs_addr.push_back(ram_addr);
                issued++;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
                check("busy_at_done", 64'(busy), 64'(0));
            end
        end
    end

    task automatic clear_tile_stats();
        beats = 0;
        first_valid_cyc = -1;
        last_hs_cyc = -1;
        done_cyc = -1;
        obs_data.delete();
        obs_addr.delete();
    endtask

    task automatic pulse_start(input int base, input int pitch, input int w, input int h);
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_base = ADDR_W'(base);
        cfg_pitch = ADDR_W'(pitch);
        cfg_w = CW_W'(w);
        cfg_h = CH_W'(h);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        // scramble cfg so only the value sampled with start can matter
        cfg_base = ADDR_W'(333);
        cfg_pitch = ADDR_W'(7);
        cfg_w = CW_W'(2);
        cfg_h = CH_W'(2);
    endtask

    task automatic wait_done(input int done0);
        int guard;
        guard = 0;
        while (done_count == done0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", 64'(done_count != done0), 64'(1));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
        check("exp_q_empty", 64'(exp_q.size()), 64'(0));
        check("addr_q_empty", 64'(exp_addr_q.size()), 64'(0));
        check("done_pulses", 64'(done_count - done0), 64'(1));
    endtask

    task automatic run_tile(input int base, input int pitch, input int w, input int h, input bit dup);
        int done0;
        clear_tile_stats();
        model_tile(base, pitch, w, h);
        done0 = done_count;
        pulse_start(base, pitch, w, h);
        if (dup) begin
            repeat (3) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done(done0);
    endtask

    initial begin
        logic [D_WIDTH-1:0] lit_data[6];
        logic [ADDR_W-1:0]  lit_addr[4];
        int done0, guard;
        lit_data = '{32'd5, 32'd6, 32'd7, 32'd13, 32'd14, 32'd15};
        lit_addr = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        reset = 1'b1;
        start = 1'b0;
        cfg_base = '0;
        cfg_pitch = '0;
        cfg_w = '0;
        cfg_h = '0;
        clear_tile_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(sif.out_valid), 64'(0));
        check("rst_outputs", 64'({busy, done, ram_re, state_dbg}), 64'(0));
        check("rst_data", 64'({sif.out_data, sif.out_last}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 4x4 full-throughput scan
        run_tile(0, 4, 4, 4, 0);
        check("t44_beats", 64'(beats), 64'(16));
        check("t44_first_lat", 64'(first_valid_cyc - start_cyc), 64'(2));
        check("t44_back_to_back", 64'(last_hs_cyc - first_valid_cyc), 64'(15));
        check("t44_done_lat", 64'(done_cyc - last_hs_cyc), 64'(1));
        check("t44_beat15", 64'(obs_data[15]), 64'(15));

        // 3x2 sub-window
        run_tile(5, 8, 3, 2, 0);
        check("t32_beats", 64'(beats), 64'(6));
        for (int i = 0; i < 6; i++) check("t32_data", 64'(obs_data[i]), 64'(lit_data[i]));

        // backpressure 1,0,0,1
        bp_mode = 1;
        run_tile(0, 4, 4, 4, 0);
        bp_mode = 0;
        check("bp_beats", 64'(beats), 64'(16));
        check("bp_last_data", 64'(obs_data[15]), 64'(15));

        // address wrap
        run_tile(1022, 4, 4, 1, 0);
        for (int i = 0; i < 4; i++) check("wrap_addr", 64'(obs_addr[i]), 64'(lit_addr[i]));

        // zero-size tile
        run_tile(0, 4, 0, 3, 0);
        check("zero_beats", 64'(beats), 64'(0));
        check("zero_no_valid", 64'(first_valid_cyc), 64'(-1));
        check("zero_done_lat", 64'(done_cyc - start_cyc), 64'(2));

        // second start while busy is ignored
        run_tile(0, 4, 4, 4, 1);
        check("dup_beats", 64'(beats), 64'(16));

        // reset after beat 5
        clear_tile_stats();
        model_tile(0, 4, 4, 4);
        done0 = done_count;
        pulse_start(0, 4, 4, 4);
        guard = 0;
        while (beats < 5 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("mid_reach_beat5", 64'(beats >= 5), 64'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        issued = 0;
        accepted = 0;
        @(negedge clk);
        check("mid_valid", 64'(sif.out_valid), 64'(0));
        check("mid_busy", 64'(busy), 64'(0));
        check("mid_done", 64'(done), 64'(0));
        repeat (20) @(negedge clk);
        check("mid_no_done", 64'(done_count), 64'(done0));
        run_tile(0, 4, 4, 4, 0);
        check("post_reset_beats", 64'(beats), 64'(16));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
